// File: rtl/dclkgen_pkg.sv
// rtl/dclkgen_pkg.sv - shared state encoding, default parameters and counter sizing for the display-clock sequencer
package dclkgen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SETTLE    = 3'd1,
    ST_STEP      = 3'd2,
    ST_WAIT_SRDY = 3'd3,
    ST_WAIT_LOCK = 3'd4,
    ST_ERROR     = 3'd5
  } dclkgen_state_t;

  localparam int DEF_MODE_W      = 2;
  localparam int DEF_SYNC_STAGES = 3;
  localparam int DEF_STABLE_CYC  = 8;
  localparam int DEF_LOCK_CYC    = 16;
  localparam int DEF_TIMEOUT_CYC = 65535;
  localparam int DEF_MAX_RETRY   = 3;

  // Width able to hold 0..n inclusive, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/dclkgen_seq_sync_ff.sv
// rtl/dclkgen_seq_sync_ff.sv - generic reset-to-0 flip-flop synchroniser chain
module sync_ff #(
  parameter int W      = 1,
  parameter int STAGES = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_chain [STAGES];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < STAGES; i++) r_chain[i] <= '0;
    end else begin
      r_chain[0] <= i_d;
      for (int i = 1; i < STAGES; i++) r_chain[i] <= r_chain[i-1];
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/dclkgen_seq.sv
// rtl/dclkgen_seq.sv - MMCM reconfiguration sequencer: debounces the mode request, steps the MMCM,
// waits for SRDY and a filtered lock, retries on timeout and reports busy/valid/error status
module dclkgen_seq
  import dclkgen_pkg::*;
#(
  parameter int MODE_W      = DEF_MODE_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int STABLE_CYC  = DEF_STABLE_CYC,
  parameter int LOCK_CYC    = DEF_LOCK_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int MAX_RETRY   = DEF_MAX_RETRY
) (
  input  logic              i_clk40,
  input  logic              i_crst,
  input  logic [MODE_W-1:0] i_resol,
  input  logic              i_srdy,
  input  logic              i_locked,
  output logic              o_sstep,
  output logic [MODE_W-1:0] o_state,
  output logic [MODE_W-1:0] o_cur_resol,
  output logic              o_busy,
  output logic              o_dclk_valid,
  output logic              o_err
);

  localparam int SW = cnt_w(STABLE_CYC);
  localparam int LW = cnt_w(LOCK_CYC);
  localparam int TW = cnt_w(TIMEOUT_CYC);
  localparam int RW = cnt_w(MAX_RETRY);

  logic [MODE_W-1:0] w_rsync;
  logic              w_lock_s;

  dclkgen_state_t    r_fsm, w_fsm_next;
  logic              w_retry;
  logic              w_timeout;
  logic              w_lock_done;
  logic              w_settle_done;

  logic [MODE_W-1:0] r_rsync_prev;
  logic [MODE_W-1:0] r_target;
  logic [MODE_W-1:0] r_cur_resol;
  logic [MODE_W-1:0] r_mode_out;
  logic [SW-1:0]     r_stable_cnt;
  logic [LW-1:0]     r_lock_cnt;
  logic [TW-1:0]     r_timer;
  logic [RW-1:0]     r_retry_cnt;
  logic              r_sstep;
  logic              r_busy;
  logic              r_dclk_valid;
  logic              r_err;

  sync_ff #(.W(MODE_W), .STAGES(SYNC_STAGES)) u_resol_sync (
    .i_clk (i_clk40),
    .i_rst (i_crst),
    .i_d   (i_resol),
    .o_q   (w_rsync)
  );

  sync_ff #(.W(1), .STAGES(2)) u_lock_sync (
    .i_clk (i_clk40),
    .i_rst (i_crst),
    .i_d   (i_locked),
    .o_q   (w_lock_s)
  );

  assign w_timeout     = (r_timer == TW'(TIMEOUT_CYC - 1));
  assign w_lock_done   = w_lock_s && (r_lock_cnt == LW'(LOCK_CYC - 1));
  assign w_settle_done = (w_rsync == r_rsync_prev) && (r_stable_cnt == SW'(STABLE_CYC - 1));

  always_ff @(posedge i_clk40) begin
    if (i_crst) r_fsm <= ST_WAIT_LOCK;
    else        r_fsm <= w_fsm_next;
  end

  // SRDY and lock take priority over a timeout landing in the same cycle.
  always_comb begin
    w_fsm_next = r_fsm;
    w_retry    = 1'b0;
    case (r_fsm)
      ST_IDLE:      if (w_rsync != r_cur_resol) w_fsm_next = ST_SETTLE;
      ST_SETTLE:    if (w_settle_done) w_fsm_next = (w_rsync == r_cur_resol) ? ST_IDLE : ST_STEP;
      ST_STEP:      w_fsm_next = ST_WAIT_SRDY;
      ST_WAIT_SRDY: begin
        if (i_srdy)         w_fsm_next = ST_WAIT_LOCK;
        else if (w_timeout) w_retry    = 1'b1;
      end
      ST_WAIT_LOCK: begin
        if (w_lock_done)    w_fsm_next = ST_IDLE;
        else if (w_timeout) w_retry    = 1'b1;
      end
      ST_ERROR:     w_fsm_next = ST_ERROR;
      default:      w_fsm_next = ST_ERROR;
    endcase
    if (w_retry) w_fsm_next = (r_retry_cnt < RW'(MAX_RETRY)) ? ST_STEP : ST_ERROR;
  end

  always_ff @(posedge i_clk40) begin
    if (i_crst) begin
      r_rsync_prev <= '0;
      r_target     <= '0;
      r_cur_resol  <= '0;
      r_mode_out   <= '0;
      r_stable_cnt <= '0;
      r_lock_cnt   <= '0;
      r_timer      <= '0;
      r_retry_cnt  <= '0;
      r_sstep      <= 1'b0;
      r_busy       <= 1'b0;
      r_dclk_valid <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_rsync_prev <= w_rsync;

      if (r_fsm == ST_SETTLE && w_rsync == r_rsync_prev) r_stable_cnt <= r_stable_cnt + 1'b1;
      else                                                 r_stable_cnt <= '0;

      if (r_fsm == ST_SETTLE && w_fsm_next == ST_STEP) r_target <= w_rsync;

      if (r_fsm == ST_WAIT_LOCK && w_lock_s && !w_lock_done) r_lock_cnt <= r_lock_cnt + 1'b1;
      else                                                     r_lock_cnt <= '0;

      // Timer saturates so a stalled wait can never wrap into a false in-budget count.
      if (r_fsm == ST_STEP || (r_fsm == ST_WAIT_SRDY && i_srdy)) r_timer <= '0;
      else if (r_timer != TW'(TIMEOUT_CYC))                       r_timer <= r_timer + 1'b1;

      if (r_fsm == ST_WAIT_LOCK && w_lock_done) begin
        r_retry_cnt <= '0;
        r_cur_resol <= r_target;
      end else if (w_retry && w_fsm_next == ST_STEP) begin
        r_retry_cnt <= r_retry_cnt + 1'b1;
      end

      r_sstep <= (r_fsm == ST_STEP);
      if (r_fsm == ST_STEP) r_mode_out <= r_target;

      r_busy       <= !(w_fsm_next inside {ST_IDLE, ST_ERROR});
      r_dclk_valid <= (w_fsm_next == ST_IDLE) && w_lock_s;
      if (w_fsm_next == ST_ERROR) r_err <= 1'b1;
    end
  end

  assign o_sstep      = r_sstep;
  assign o_state      = r_mode_out;
  assign o_cur_resol  = r_cur_resol;
  assign o_busy       = r_busy;
  assign o_dclk_valid = r_dclk_valid;
  assign o_err        = r_err;

endmodule
